// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline hazard/exception controller:
// PC-source select values, exception-entry FSM states and default vectors.
package pipe_ctrl_pkg;

    localparam logic [1:0] PCSEL_SEQ = 2'd0;
    localparam logic [1:0] PCSEL_BR  = 2'd1;
    localparam logic [1:0] PCSEL_JMP = 2'd2;
    localparam logic [1:0] PCSEL_EXC = 2'd3;

    typedef enum logic {
        RUN   = 1'b0,
        ENTRY = 1'b1
    } ctrl_state_e;

    localparam logic [31:0] DEF_ILLOP_VEC = 32'h8000_0004;
    localparam logic [31:0] DEF_XADR_VEC  = 32'h8000_0008;

endpackage

// File: rtl/pipe_hazard_ctrl_irq_sync.sv
// External interrupt front end: 2-flop synchronizer, rising-edge detect on
// the synchronized level, and a pending latch cleared when the interrupt is
// taken. A new edge arriving in the same cycle as the clear keeps it pending.
module irq_sync (
    input  logic clk,
    input  logic reset,
    input  logic irq,
    input  logic take,
    output logic irq_pending
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic hist_q, hist_d;
    logic pend_q, pend_d;
    logic rise;

    // Next-state for synchronizer chain, edge history and pending latch.
    always_comb begin
        sync1_d = irq;
        sync2_d = sync1_q;
        hist_d  = sync2_q;
        rise    = sync2_q & ~hist_q;
        pend_d  = rise | (pend_q & ~take);
    end

    // Interrupt state registers; reset discards any pending request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            hist_q  <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            hist_q  <= hist_d;
            pend_q  <= pend_d;
        end
    end

    assign irq_pending = pend_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush/redirect control for the 5-stage core. One action per
// cycle chosen by fixed priority: taken branch, illegal op, interrupt,
// load-use stall, jump. Exceptions are blocked in user-mode-only fashion
// (kernel PCs never trap) and for one cycle after entry while ID holds a
// bubble.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter logic [31:0] ILLOP_VEC = DEF_ILLOP_VEC,
    parameter logic [31:0] XADR_VEC  = DEF_XADR_VEC,
    parameter int          CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic [31:0]      id_pc,
    input  logic             id_jump,
    input  logic             id_illop,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rt,
    input  logic             ex_branch_taken,
    input  logic             irq,
    output logic             pc_stall,
    output logic             ifid_stall,
    output logic             ifid_flush,
    output logic             idex_stall,
    output logic             idex_flush,
    output logic             illop,
    output logic             xadr,
    output logic [1:0]       pc_sel,
    output logic [31:0]      exc_vec,
    output logic             epc_we,
    output logic [31:0]      epc,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    ctrl_state_e      state_q, state_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic             irq_pending;
    logic             lu;
    logic             elig;

    irq_sync u_irq_sync (
        .clk         (clk),
        .reset       (reset),
        .irq         (irq),
        .take        (xadr),
        .irq_pending (irq_pending)
    );

    // Hazard detection and exception eligibility.
    always_comb begin
        lu   = ex_mem_read && (ex_rt != 5'd0) &&
               ((id_uses_rs && (ex_rt == id_rs)) || (id_uses_rt && (ex_rt == id_rt)));
        elig = (state_q == RUN) && !id_pc[31] && !ex_branch_taken;
    end

    // Priority mux: exactly one front-end action per cycle.
    always_comb begin
        pc_stall   = 1'b0;
        ifid_stall = 1'b0;
        ifid_flush = 1'b0;
        idex_stall = 1'b0;
        idex_flush = 1'b0;
        illop      = 1'b0;
        xadr       = 1'b0;
        pc_sel     = PCSEL_SEQ;
        exc_vec    = 32'd0;
        epc_we     = 1'b0;
        if (ex_branch_taken) begin
            pc_sel     = PCSEL_BR;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (elig && id_illop) begin
            illop      = 1'b1;
            pc_sel     = PCSEL_EXC;
            exc_vec    = ILLOP_VEC;
            ifid_flush = 1'b1;
            epc_we     = 1'b1;
        end else if (elig && irq_pending) begin
            xadr       = 1'b1;
            pc_sel     = PCSEL_EXC;
            exc_vec    = XADR_VEC;
            ifid_flush = 1'b1;
            epc_we     = 1'b1;
        end else if (lu) begin
            pc_stall   = 1'b1;
            ifid_stall = 1'b1;
            idex_stall = 1'b1;
        end else if (id_jump) begin
            pc_sel     = PCSEL_JMP;
            ifid_flush = 1'b1;
        end
    end

    // Exception-entry FSM and saturating event counters, next state.
    always_comb begin
        state_d     = (illop || xadr) ? ENTRY : RUN;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (idex_stall && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end
        if (ifid_flush && (flush_cnt_q != CNT_MAX)) begin
            flush_cnt_d = flush_cnt_q + CNT_ONE;
        end
    end

    // FSM state and counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= RUN;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign epc       = id_pc;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: each stimulus cycle pushes its
// hand-derived expected outputs; a negedge monitor pops and compares.
module tb_pipe_hazard_ctrl;
    import pipe_ctrl_pkg::*;

    localparam int CNT_W = 16;

    // ctrl bit order: pc_stall, ifid_stall, ifid_flush, idex_stall,
    //                 idex_flush, illop, xadr, epc_we
    localparam logic [7:0] C_NONE  = 8'b0000_0000;
    localparam logic [7:0] C_STALL = 8'b1101_0000;
    localparam logic [7:0] C_BR    = 8'b0010_1000;
    localparam logic [7:0] C_JMP   = 8'b0010_0000;
    localparam logic [7:0] C_ILL   = 8'b0010_0101;
    localparam logic [7:0] C_XADR  = 8'b0010_0011;

    localparam logic [31:0] V_ILL  = 32'h8000_0004;
    localparam logic [31:0] V_XADR = 32'h8000_0008;

    typedef struct packed {
        logic [7:0]       ctrl;
        logic [1:0]       sel;
        logic [31:0]      vec;
        logic [31:0]      epc;
        logic [CNT_W-1:0] sc;
        logic [CNT_W-1:0] fc;
        logic             full;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset;
    logic [4:0]       id_rs, id_rt, ex_rt;
    logic             id_uses_rs, id_uses_rt, id_jump, id_illop;
    logic             ex_mem_read, ex_branch_taken, irq;
    logic [31:0]      id_pc;
    logic             pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush;
    logic             illop, xadr, epc_we;
    logic [1:0]       pc_sel;
    logic [31:0]      exc_vec, epc;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    exp_t             exp_q[$];
    string            name_q[$];
    logic [CNT_W-1:0] m_stall, m_flush;
    int               checks = 0;
    int               failures = 0;

    pipe_hazard_ctrl #(.CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_pc(id_pc), .id_jump(id_jump), .id_illop(id_illop),
        .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .ex_branch_taken(ex_branch_taken),
        .irq(irq),
        .pc_stall(pc_stall), .ifid_stall(ifid_stall), .ifid_flush(ifid_flush),
        .idex_stall(idex_stall), .idex_flush(idex_flush),
        .illop(illop), .xadr(xadr), .pc_sel(pc_sel), .exc_vec(exc_vec),
        .epc_we(epc_we), .epc(epc), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        id_rs = 5'd0; id_rt = 5'd0; ex_rt = 5'd0;
        id_uses_rs = 1'b0; id_uses_rt = 1'b0; id_jump = 1'b0; id_illop = 1'b0;
        ex_mem_read = 1'b0; ex_branch_taken = 1'b0;
        id_pc = 32'h0040_0000;
    endtask

    task automatic cyc(input string nm, input logic [7:0] c, input logic [1:0] s,
                       input logic [31:0] v, input bit f);
        exp_t e;
        e.ctrl = c; e.sel = s; e.vec = v; e.epc = id_pc;
        e.sc = m_stall; e.fc = m_flush; e.full = f;
        exp_q.push_back(e);
        name_q.push_back(nm);
        if (c[4]) m_stall = sat_inc(m_stall);
        if (c[5]) m_flush = sat_inc(m_flush);
        tick();
    endtask

    // Monitor: compare the DUT's outputs against the oldest queued expectation.
    exp_t       mon_e;
    string      mon_nm;
    logic [7:0] act_ctrl;
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e  = exp_q.pop_front();
            mon_nm = name_q.pop_front();
            act_ctrl = {pc_stall, ifid_stall, ifid_flush, idex_stall,
                        idex_flush, illop, xadr, epc_we};
            checks++;
            if (act_ctrl !== mon_e.ctrl || pc_sel !== mon_e.sel) begin
                failures++;
                $display("FAIL %s ctrl/pc_sel: got %b/%0d want %b/%0d",
                         mon_nm, act_ctrl, pc_sel, mon_e.ctrl, mon_e.sel);
            end
            checks++;
            if (stall_cnt !== mon_e.sc || flush_cnt !== mon_e.fc) begin
                failures++;
                $display("FAIL %s counters: got stall=%h flush=%h want stall=%h flush=%h",
                         mon_nm, stall_cnt, flush_cnt, mon_e.sc, mon_e.fc);
            end
            if (mon_e.sel == PCSEL_EXC || mon_e.full) begin
                checks++;
                if (exc_vec !== mon_e.vec) begin
                    failures++;
                    $display("FAIL %s exc_vec: got %h want %h", mon_nm, exc_vec, mon_e.vec);
                end
            end
            if (mon_e.ctrl[0] || mon_e.full) begin
                checks++;
                if (epc !== mon_e.epc) begin
                    failures++;
                    $display("FAIL %s epc: got %h want %h", mon_nm, epc, mon_e.epc);
                end
            end
        end
    end

    initial begin
        reset = 1'b1;
        irq   = 1'b0;
        set_idle();
        id_pc   = 32'd0;
        m_stall = '0;
        m_flush = '0;
        tick();

        // Reset state with all inputs low.
        cyc("reset_state", C_NONE, PCSEL_SEQ, 32'd0, 1'b1);
        cyc("reset_hold", C_NONE, PCSEL_SEQ, 32'd0, 1'b1);
        reset = 1'b0;
        cyc("idle", C_NONE, PCSEL_SEQ, 32'd0, 1'b1);

        // Load-use hazards.
        set_idle();
        ex_mem_read = 1'b1; ex_rt = 5'd5; id_rs = 5'd5; id_uses_rs = 1'b1;
        cyc("lu_rs", C_STALL, PCSEL_SEQ, 32'd0, 1'b0);
        set_idle();
        cyc("lu_done", C_NONE, PCSEL_SEQ, 32'd0, 1'b0);
        ex_mem_read = 1'b1; ex_rt = 5'd0; id_rs = 5'd0; id_uses_rs = 1'b1;
        cyc("lu_rt0", C_NONE, PCSEL_SEQ, 32'd0, 1'b0);
        set_idle();
        ex_mem_read = 1'b1; ex_rt = 5'd7; id_rt = 5'd7; id_uses_rt = 1'b1;
        cyc("lu_rt", C_STALL, PCSEL_SEQ, 32'd0, 1'b0);
        id_uses_rt = 1'b0;
        cyc("lu_unused", C_NONE, PCSEL_SEQ, 32'd0, 1'b0);
        ex_mem_read = 1'b0; id_uses_rt = 1'b1;
        cyc("no_load", C_NONE, PCSEL_SEQ, 32'd0, 1'b0);

        // Branch beats exception; illegal op and ENTRY blocking.
        set_idle();
        ex_branch_taken = 1'b1; id_illop = 1'b1; id_pc = 32'h0040_0010;
        cyc("br_over_ill", C_BR, PCSEL_BR, 32'd0, 1'b0);
        set_idle();
        id_illop = 1'b1; id_pc = 32'h0040_0020;
        cyc("illop", C_ILL, PCSEL_EXC, V_ILL, 1'b0);
        id_pc = 32'h0040_0024;
        cyc("entry_block", C_NONE, PCSEL_SEQ, 32'd0, 1'b0);
        cyc("illop_again", C_ILL, PCSEL_EXC, V_ILL, 1'b0);
        set_idle();
        cyc("after_entry", C_NONE, PCSEL_SEQ, 32'd0, 1'b0);
        id_illop = 1'b1; id_pc = 32'h8000_0010;
        cyc("kern_illop", C_NONE, PCSEL_SEQ, 32'd0, 1'b0);

        // Jump and its priority against stall / illegal op.
        set_idle();
        id_jump = 1'b1;
        cyc("jump", C_JMP, PCSEL_JMP, 32'd0, 1'b0);
        ex_mem_read = 1'b1; ex_rt = 5'd3; id_rs = 5'd3; id_uses_rs = 1'b1;
        cyc("lu_over_jump", C_STALL, PCSEL_SEQ, 32'd0, 1'b0);
        id_jump = 1'b0; id_illop = 1'b1; id_pc = 32'h0040_0030;
        cyc("ill_over_lu", C_ILL, PCSEL_EXC, V_ILL, 1'b0);
        set_idle();
        cyc("entry2", C_NONE, PCSEL_SEQ, 32'd0, 1'b0);

        // Interrupt latency: raised before edge k, taken after edge k+2.
        id_pc = 32'h0040_0040;
        irq = 1'b1;
        cyc("irq_k", C_NONE, PCSEL_SEQ, 32'd0, 1'b0);
        cyc("irq_k1", C_NONE, PCSEL_SEQ, 32'd0, 1'b0);
        cyc("irq_k2", C_NONE, PCSEL_SEQ, 32'd0, 1'b0);
        cyc("xadr", C_XADR, PCSEL_EXC, V_XADR, 1'b0);
        cyc("xadr_entry", C_NONE, PCSEL_SEQ, 32'd0, 1'b0);
        cyc("xadr_cleared", C_NONE, PCSEL_SEQ, 32'd0, 1'b0);
        irq = 1'b0;
        for (int i = 0; i < 3; i++) cyc("irq_low", C_NONE, PCSEL_SEQ, 32'd0, 1'b0);

        // Pending held through kernel mode, branch flush and illop/ENTRY.
        id_pc = 32'h8000_0100;
        irq = 1'b1;
        for (int i = 0; i < 6; i++) cyc("kern_hold", C_NONE, PCSEL_SEQ, 32'd0, 1'b0);
        ex_branch_taken = 1'b1; id_pc = 32'h0040_0050;
        cyc("br_pend", C_BR, PCSEL_BR, 32'd0, 1'b0);
        ex_branch_taken = 1'b0; id_illop = 1'b1; id_pc = 32'h0040_0054;
        cyc("ill_pend", C_ILL, PCSEL_EXC, V_ILL, 1'b0);
        id_illop = 1'b0; id_pc = 32'h0040_0058;
        cyc("entry_pend", C_NONE, PCSEL_SEQ, 32'd0, 1'b0);
        cyc("xadr_late", C_XADR, PCSEL_EXC, V_XADR, 1'b0);
        cyc("entry3", C_NONE, PCSEL_SEQ, 32'd0, 1'b0);
        cyc("no_repeat", C_NONE, PCSEL_SEQ, 32'd0, 1'b0);
        irq = 1'b0;

        // Stall counter saturation.
        set_idle();
        ex_mem_read = 1'b1; ex_rt = 5'd9; id_rt = 5'd9; id_uses_rt = 1'b1;
        for (int i = 0; i < (1 << CNT_W) + 3; i++) begin
            m_stall = sat_inc(m_stall);
            tick();
        end
        cyc("sat", C_STALL, PCSEL_SEQ, 32'd0, 1'b0);
        cyc("sat_hold", C_STALL, PCSEL_SEQ, 32'd0, 1'b0);

        // Mid-cycle reset pulse with an interrupt pending.
        set_idle();
        id_pc = 32'h8000_0200;
        irq = 1'b1;
        for (int i = 0; i < 4; i++) cyc("pend_kern", C_NONE, PCSEL_SEQ, 32'd0, 1'b0);
        #1 reset = 1'b1;
        #1 reset = 1'b0;
        irq = 1'b0;
        m_stall = '0;
        m_flush = '0;
        id_pc = 32'h0040_0060;
        cyc("post_reset", C_NONE, PCSEL_SEQ, 32'd0, 1'b0);
        for (int i = 0; i < 4; i++) cyc("post_reset_user", C_NONE, PCSEL_SEQ, 32'd0, 1'b0);

        tick();
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d queued want 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

- Central pipeline control for the 5-stage MIPS core.
- Decides, every cycle, whether to stall, flush or redirect the front end, and drives the `stall`, `flush`, `illop` and `xadr` controls consumed by the ID/EX pipeline register, plus the PC-source select and EPC capture.
- Sits between the ID-stage decoder, the EX-stage branch resolver and the external interrupt line.
- Holds the interrupt synchronizer/pending latch, an exception-entry FSM and saturating event counters.

## Interface
Parameters:
- ILLOP_VEC, 32'h80000004, fetch address on illegal-opcode exception
- XADR_VEC, 32'h80000008, fetch address on external interrupt
- CNT_W, 16, width of each event counter

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high
- id_rs, id_rt  in  5 each  source register fields of instruction in ID
- id_uses_rs, id_uses_rt  in  1 each  ID instruction reads that field
- id_pc  in  32  PC of instruction in ID; bit 31 = kernel mode
- id_jump  in  1  ID holds j/jal/jr/jalr
- id_illop  in  1  ID decoder flags an undefined opcode
- ex_mem_read  in  1  EX holds a load
- ex_rt  in  5  load destination in EX
- ex_branch_taken  in  1  EX branch resolved taken
- irq  in  1  asynchronous external interrupt request, level
- pc_stall  out  1  PC register holds
- ifid_stall  out  1  IF/ID register holds
- ifid_flush  out  1  IF/ID register loads a bubble
- idex_stall  out  1  ID/EX inserts a bubble (drives its `stall`)
- idex_flush  out  1  ID/EX loads a bubble (drives its `flush`)
- illop  out  1  illegal-op exception taken this cycle
- xadr  out  1  interrupt taken this cycle
- pc_sel  out  2  0 sequential, 1 branch target, 2 jump target, 3 exception vector
- exc_vec  out  32  ILLOP_VEC or XADR_VEC; valid when pc_sel==3
- epc_we  out  1  write EPC this cycle
- epc  out  32  value for EPC (= id_pc)
- stall_cnt, flush_cnt  out  CNT_W each  saturating event counters

## Operation
- Load-use hazard (`lu`) is true when all of the following hold:
  - ex_mem_read
  - ex_rt != 0
  - (id_uses_rs && ex_rt==id_rs) || (id_uses_rt && ex_rt==id_rt)
- Exception eligibility (`elig`): state==RUN && id_pc[31]==0 && !ex_branch_taken.
- Priority, highest first; exactly one action per cycle:
  1. ex_branch_taken:
     - pc_sel=1, ifid_flush=1, idex_flush=1.
  2. elig && id_illop:
     - illop=1, pc_sel=3, exc_vec=ILLOP_VEC, ifid_flush=1, epc_we=1, epc=id_pc.
     - State moves to ENTRY.
  3. elig && irq_pending:
     - xadr=1, pc_sel=3, exc_vec=XADR_VEC, ifid_flush=1, epc_we=1, epc=id_pc.
     - Pending is cleared. State moves to ENTRY.
  4. lu:
     - pc_stall=1, ifid_stall=1, idex_stall=1.
  5. id_jump:
     - pc_sel=2, ifid_flush=1.
  6. Otherwise all control outputs are 0 and pc_sel=0.
- illop and xadr are never both 1. When id_illop and pending coincide, illop wins and pending is retained.
- FSM states:
  - RUN: exceptions allowed.
  - ENTRY: entered on any exception. Exceptions are blocked here because ID holds a flushed bubble. Returns to RUN unconditionally on the next edge.
- Interrupt path:
  - irq passes through a 2-flop synchronizer.
  - A rising edge of the synchronized signal sets irq_pending. Taking the interrupt clears it.
  - Simultaneous set and clear: set wins.
  - Pending stays set across kernel-mode execution, branch flushes and ENTRY.
- Counters:
  - stall_cnt increments on each cycle with idex_stall=1.
  - flush_cnt increments on each cycle with ifid_flush=1.
  - Both saturate at all-ones and never wrap.

## Timing
- All control outputs are combinational from current inputs and registered state; zero-cycle latency.
- irq latency: irq is high at edge k, synchronized high after k+1, pending set at edge k+2. xadr can assert in the cycle following edge k+2.
- Load-use stall lasts exactly one cycle, because the load leaves EX on the next edge.
- Reset (asynchronous):
  - state=RUN, synchronizer=0, irq_pending=0, counters=0.
  - With all inputs low, every output is 0 and pc_sel=0.
- Reset asserted during ENTRY or with irq pending discards both.

## Structure
- Package `pipe_ctrl_pkg` holds:
  - the pc_sel encoding constants (PCSEL_SEQ/BR/JMP/EXC),
  - the FSM state type {RUN, ENTRY},
  - default vector constants.
- One sub-module, `irq_sync`: 2-flop synchronizer, edge detect and pending flop, with a `take` clear input and an `irq_pending` output.
- Priority mux, FSM and counters live in the top module.

## Test plan
- Load-use: ex_mem_read=1, ex_rt=5, id_rs=5, id_uses_rs=1 → one cycle of pc_stall=ifid_stall=idex_stall=1, stall_cnt 0→1; ex_rt=0 with the same inputs → no stall.
- Branch vs exception: ex_branch_taken=1, id_illop=1, id_pc=0x00400010 → pc_sel=1, both flushes set, illop=0, epc_we=0, state stays RUN.
- Illegal op: id_illop=1, id_pc=0x00400020 → illop=1, pc_sel=3, exc_vec=0x80000004, epc=0x00400020. Next cycle, with id_illop still 1 → illop=0 (ENTRY).
- Interrupt: irq rises before edge k → xadr=1 in the cycle after edge k+2, with exc_vec=0x80000008. With id_pc=0x80000100, xadr is withheld until id_pc[31]=0, and pending stays set.
- Saturation and reset: force 2^CNT_W+3 load-use cycles → stall_cnt=16'hFFFF. Then pulse reset mid-cycle with irq pending → counters 0, no xadr afterwards.
